// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an 8-bit adder result producer and sum_accumulator.
//   in_valid/in_ready : result handshake; Sum/cout/overflow carry the adder result
//   out_valid/out_ready : block-result handshake; acc/ovf_count/sat carry the block result
// master: producer/consumer side. slave: accumulator side.
interface sum_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Sum;
  logic        cout;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] acc;
  logic [3:0]  ovf_count;
  logic        sat;

  modport master (
    output in_valid, Sum, cout, overflow, out_ready,
    input  in_ready, out_valid, acc, ovf_count, sat
  );

  modport slave (
    input  in_valid, Sum, cout, overflow, out_ready,
    output in_ready, out_valid, acc, ovf_count, sat
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES 9-bit adder results ({cout,Sum}) into a saturating 16-bit
// total, counts results flagged with signed overflow, then holds the block result
// until the consumer takes it.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   clear : synchronous restart, overrides any coincident accept or out_ready
//   bus   : slave side of sum_accumulator_if (input results, block-result output)
module sum_accumulator #(
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  sum_accumulator_if.slave   bus
);

  typedef enum logic {StAccum, StHold} state_e;

  localparam logic [7:0] NLast = 8'(N_SAMPLES);

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  ovf_q, ovf_d;
  logic        sat_q, sat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [16:0] sum_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= 16'h0000;
      ovf_q   <= 4'd0;
      sat_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    sum_wide = {1'b0, acc_q} + {8'd0, bus.cout, bus.Sum};

    if (clear) begin
      state_d = StAccum;
      acc_d   = 16'h0000;
      ovf_d   = 4'd0;
      sat_d   = 1'b0;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        StAccum: begin
          // in_ready is 1 here, so in_valid alone qualifies the accept
          if (bus.in_valid) begin
            if (sum_wide[16]) begin
              acc_d = 16'hFFFF;
              sat_d = 1'b1;
            end else begin
              acc_d = sum_wide[15:0];
            end
            if (bus.overflow && (ovf_q != 4'hF)) begin
              ovf_d = ovf_q + 4'd1;
            end
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == NLast) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StAccum;
            acc_d   = 16'h0000;
            ovf_d   = 4'd0;
            sat_d   = 1'b0;
            cnt_d   = 8'd0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StHold);
  assign bus.acc       = acc_q;
  assign bus.ovf_count = ovf_q;
  assign bus.sat       = sat_q;

endmodule
